// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: frame state
// encoding and the parity helper.
package uart_pkg;

  localparam int MAX_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT,
    ERROR
  } state_t;

  // Even parity is the XOR of the payload; odd parity is its inverse.
  function automatic logic parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                  input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..divider and strobes bit_end on the last clock
// of each bit. The divider is captured on load so mid-frame changes are ignored.
module uart_baud_gen #(
  parameter int BAUD_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [BAUD_WIDTH-1:0] divider,
  output logic                  bit_end
);

  logic [BAUD_WIDTH-1:0] count;
  logic [BAUD_WIDTH-1:0] divider_q;

  assign bit_end = !clear && (count == divider_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      divider_q <= '0;
    end else begin
      if (load) begin
        divider_q <= divider;
      end
      if (clear || bit_end) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH payload bits LSB first, optional
// parity bit, one stop bit. Settings are captured when a request is accepted.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_data,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  tx,
  input  logic [BAUD_WIDTH-1:0] baud_divider,
  input  logic                  parity_en,
  input  logic                  parity_type_odd
);

  localparam int POS_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [POS_WIDTH-1:0] LAST_POS = POS_WIDTH'(DATA_WIDTH - 1);

  state_t                 state;
  logic [DATA_WIDTH-1:0]  shift_reg;
  logic [POS_WIDTH-1:0]   bit_position;
  logic                   parity_en_q;
  logic                   parity_bit_q;
  logic                   accept;
  logic                   bit_end;

  assign accept = (state == IDLE) && valid_data;
  assign busy   = (state != IDLE);

  uart_baud_gen #(
    .BAUD_WIDTH(BAUD_WIDTH)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .load   (accept),
    .divider(baud_divider),
    .bit_end(bit_end)
  );

  // tx is registered one state ahead: each transition drives the level of
  // the bit that the new state represents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx           <= 1'b1;
      done         <= 1'b0;
      shift_reg    <= '0;
      bit_position <= '0;
      parity_en_q  <= 1'b0;
      parity_bit_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (valid_data) begin
            state        <= START_BIT;
            tx           <= 1'b0;
            shift_reg    <= data;
            bit_position <= '0;
            parity_en_q  <= parity_en;
            parity_bit_q <= parity(MAX_DATA_WIDTH'(data), parity_type_odd);
          end
        end
        START_BIT: begin
          if (bit_end) begin
            state     <= DATA_BITS;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        DATA_BITS: begin
          if (bit_end) begin
            if (bit_position == LAST_POS) begin
              if (parity_en_q) begin
                state <= PARITY_BIT;
                tx    <= parity_bit_q;
              end else begin
                state <= STOP_BIT;
                tx    <= 1'b1;
              end
            end else begin
              bit_position <= bit_position + 1'b1;
              tx           <= shift_reg[0];
              shift_reg    <= shift_reg >> 1;
            end
          end
        end
        PARITY_BIT: begin
          if (bit_end) begin
            state <= STOP_BIT;
            tx    <= 1'b1;
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames, hand-written corner
// sequences and random frames, all checked against a bit-list frame model.
module tb_uart_tx;

  logic        clk;
  logic        rst;
  logic        valid_data;
  logic [7:0]  data;
  logic        busy;
  logic        done;
  logic        tx;
  logic [11:0] baud_divider;
  logic        parity_en;
  logic        parity_type_odd;

  int checks;
  int errors;

  uart_tx #(
    .DATA_WIDTH(8),
    .BAUD_WIDTH(12)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_data     (valid_data),
    .data           (data),
    .busy           (busy),
    .done           (done),
    .tx             (tx),
    .baud_divider   (baud_divider),
    .parity_en      (parity_en),
    .parity_type_odd(parity_type_odd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       pe;
    logic       odd;
    int         exp_busy;
    logic       exp_parity;
  } vec_t;

  vec_t vecs[$];

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request at a negedge; it is taken at the following posedge.
  task automatic applyStimulus(input logic [7:0] d, input int dv,
                               input logic pe, input logic od);
    @(negedge clk);
    data            = d;
    baud_divider    = 12'(dv);
    parity_en       = pe;
    parity_type_odd = od;
    valid_data      = 1'b1;
    @(posedge clk);
    #1 valid_data = 1'b0;
  endtask

  // Frame model: list of line levels, each held dv+1 clocks, then one done cycle.
  task automatic checkOutput(input logic [7:0] d, input int dv, input logic pe,
                             input logic od, output int busy_len,
                             output logic par_seen);
    logic bits[$];
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(logic'(($countones(d) % 2) == 1) ^ od);
    bits.push_back(1'b1);
    busy_len = 0;
    par_seen = 1'b0;
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c <= dv; c++) begin
        @(negedge clk);
        checkBit($sformatf("tx bit%0d cyc%0d", b, c), tx, bits[b]);
        checkBit("done low in frame", done, 1'b0);
        if (busy) busy_len++;
        if (pe && b == 9 && c == 0) par_seen = tx;
      end
    end
    @(negedge clk);
    checkBit("done pulse", done, 1'b1);
    checkBit("busy after stop", busy, 1'b0);
    checkBit("tx idle after stop", tx, 1'b1);
  endtask

  initial begin
    int          blen;
    logic        pseen;
    logic [7:0]  rd;
    int          rdiv;
    logic        rpe;
    logic        rod;

    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    valid_data      = 1'b0;
    data            = '0;
    baud_divider    = '0;
    parity_en       = 1'b0;
    parity_type_odd = 1'b0;

    vecs.push_back('{8'hA5, 3, 1'b0, 1'b0, 40, 1'b0});
    vecs.push_back('{8'hA5, 3, 1'b1, 1'b0, 44, 1'b0});
    vecs.push_back('{8'hA5, 3, 1'b1, 1'b1, 44, 1'b1});
    vecs.push_back('{8'h3C, 0, 1'b0, 1'b0, 10, 1'b0});
    vecs.push_back('{8'h01, 0, 1'b1, 1'b0, 11, 1'b1});
    vecs.push_back('{8'hFF, 2, 1'b1, 1'b1, 33, 1'b1});
    vecs.push_back('{8'h00, 1, 1'b1, 1'b0, 22, 1'b0});

    repeat (3) @(negedge clk);
    checkBit("reset tx", tx, 1'b1);
    checkBit("reset busy", busy, 1'b0);
    checkBit("reset done", done, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] table-driven frames");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].div, vecs[i].pe, vecs[i].odd);
      checkOutput(vecs[i].data, vecs[i].div, vecs[i].pe, vecs[i].odd, blen, pseen);
      checkInt($sformatf("busy length vec%0d", i), blen, vecs[i].exp_busy);
      if (vecs[i].pe) checkBit($sformatf("parity bit vec%0d", i), pseen, vecs[i].exp_parity);
    end

    $display("[TB] settings changed during busy");
    applyStimulus(8'hA5, 3, 1'b0, 1'b0);
    fork
      checkOutput(8'hA5, 3, 1'b0, 1'b0, blen, pseen);
      begin
        repeat (5) @(negedge clk);
        data            = 8'hFF;
        baud_divider    = 12'd1;
        parity_en       = 1'b1;
        parity_type_odd = 1'b0;
        valid_data      = 1'b1;
        @(negedge clk);
        valid_data = 1'b0;
      end
    join
    checkInt("busy length unchanged", blen, 40);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkBit("no second frame tx", tx, 1'b1);
      checkBit("no second frame busy", busy, 1'b0);
    end
    applyStimulus(8'hFF, 1, 1'b1, 1'b0);
    checkOutput(8'hFF, 1, 1'b1, 1'b0, blen, pseen);
    checkInt("new settings busy", blen, 22);
    checkBit("new settings parity", pseen, 1'b0);

    $display("[TB] back-to-back frames");
    @(negedge clk);
    data            = 8'h00;
    baud_divider    = 12'd3;
    parity_en       = 1'b0;
    parity_type_odd = 1'b0;
    valid_data      = 1'b1;
    @(posedge clk);
    #1 data = 8'hFF;
    checkOutput(8'h00, 3, 1'b0, 1'b0, blen, pseen);
    @(posedge clk);
    #1 data = 8'h55;
    checkOutput(8'hFF, 3, 1'b0, 1'b0, blen, pseen);
    @(posedge clk);
    #1 valid_data = 1'b0;
    checkOutput(8'h55, 3, 1'b0, 1'b0, blen, pseen);
    @(negedge clk);
    checkBit("idle after burst", busy, 1'b0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hA5, 3, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    checkBit("busy before reset", busy, 1'b1);
    rst = 1'b1;
    #1;
    checkBit("tx at reset", tx, 1'b1);
    checkBit("busy at reset", busy, 1'b0);
    checkBit("done at reset", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h3C, 3, 1'b0, 1'b0);
    checkOutput(8'h3C, 3, 1'b0, 1'b0, blen, pseen);
    checkInt("post-reset busy", blen, 40);

    $display("[TB] random frames");
    for (int n = 0; n < 24; n++) begin
      rd   = 8'($urandom_range(0, 255));
      rdiv = int'($urandom_range(0, 4));
      rpe  = 1'($urandom_range(0, 1));
      rod  = 1'($urandom_range(0, 1));
      applyStimulus(rd, rdiv, rpe, rod);
      checkOutput(rd, rdiv, rpe, rod, blen, pseen);
      checkInt($sformatf("random busy %0d", n), blen, (rdiv + 1) * (rpe ? 11 : 10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
